// File: rtl/prewish_mask_loader_if.sv
// prewish_mask_loader_if: load strobe and mask bus from the loader to prewish_mentor.
interface prewish_mask_loader_if #(parameter int DATA_W = 8);
    logic              STB_O;
    logic [DATA_W-1:0] DAT_O;
    modport master (output STB_O, output DAT_O);
    modport slave  (input STB_O, input DAT_O);
endinterface

// File: rtl/prewish_mask_loader.sv
// prewish_mask_loader: synchronised, debounced LOAD button issuing one-cycle DIP mask strobes.
// Optional auto-repeat while the button is held: define PREWISH_LOADER_AUTOREPEAT_EN.
module prewish_mask_loader #(
    parameter int DEBOUNCE_BITS = 17,
    parameter int REPEAT_BITS   = 24,
    parameter int DATA_W        = 8
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  i_button,
    input  logic [DATA_W-1:0]     i_dip,
    prewish_mask_loader_if.master bus,
    output logic                  o_held
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HELD} state_t;
    state_t                   state_q, state_d;
    logic                     btn_s1_q, btn_s2_q;
    logic [DATA_W-1:0]        dip_s1_q, dip_s2_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     deb_q, deb_d;
    logic                     stb_q, stb_d;
    logic [DATA_W-1:0]        dat_q, dat_d;
    logic                     pressed;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
    logic [REPEAT_BITS-1:0]   rpt_q, rpt_d;
`endif
    assign pressed    = ~btn_s2_q;
    assign bus.STB_O  = stb_q;
    assign bus.DAT_O  = dat_q;
    assign o_held     = deb_q;
    // any sample agreeing with the debounced level restarts the hold-off count
    always_comb begin
        cnt_d = (pressed == deb_q || cnt_q == '1) ? '0 : cnt_q + 1'b1;
        deb_d = (pressed != deb_q && cnt_q == '1) ? pressed : deb_q;
    end
    always_comb begin
        state_d = state_q;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
        rpt_d = '0;
`endif
        case (state_q)
            S_IDLE: state_d = deb_q ? S_LOAD : S_IDLE;
            S_LOAD: state_d = S_HELD;
            S_HELD: begin
                state_d = deb_q ? S_HELD : S_IDLE;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
                rpt_d = rpt_q + 1'b1;
                if (deb_q && rpt_q == '1) state_d = S_LOAD;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        stb_d = state_d == S_LOAD;
        dat_d = stb_d ? dip_s2_q : dat_q;
    end
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            btn_s1_q <= 1'b1;
            btn_s2_q <= 1'b1;
            dip_s1_q <= '0;
            dip_s2_q <= '0;
            cnt_q    <= '0;
            deb_q    <= 1'b0;
            state_q  <= S_IDLE;
            stb_q    <= 1'b0;
            dat_q    <= '0;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
            rpt_q    <= '0;
`endif
        end else begin
            btn_s1_q <= i_button;
            btn_s2_q <= btn_s1_q;
            dip_s1_q <= i_dip;
            dip_s2_q <= dip_s1_q;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
            state_q  <= state_d;
            stb_q    <= stb_d;
            dat_q    <= dat_d;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
            rpt_q    <= rpt_d;
`endif
        end
    end
endmodule

// File: tb/tb_prewish_mask_loader.sv
// tb_prewish_mask_loader: directed and randomized checks of the loader against an event-level model.
// Honours PREWISH_LOADER_AUTOREPEAT_EN so both builds can be checked.
module tb_prewish_mask_loader;
    localparam int DB  = 3;
    localparam int RB  = 4;
    localparam int W   = 8;
    localparam int WIN = 1 << DB;
`ifdef PREWISH_LOADER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic         CLK_I = 1'b0;
    logic         RST_I = 1'b0;
    logic         i_button = 1'b1;
    logic [W-1:0] i_dip = '0;
    logic         o_held;
    prewish_mask_loader_if #(.DATA_W(W)) bus();
    prewish_mask_loader #(.DEBOUNCE_BITS(DB), .REPEAT_BITS(RB), .DATA_W(W)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .i_button(i_button), .i_dip(i_dip),
        .bus(bus.master), .o_held(o_held));
    always #5 CLK_I = ~CLK_I;
    int vectors = 0, errors = 0;
    int edge_n, strobes = 0, last_stb_edge, since, mark, s0;
    bit m_deb, m_stb, rose, held_ok, found;
    logic [W-1:0] m_dat;
    bit bh[2];
    logic [W-1:0] dh[2];
    bit win[$];
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_deb = 0; m_stb = 0; m_dat = '0; rose = 0; held_ok = 0; since = 0;
        bh[0] = 1; bh[1] = 1; dh[0] = '0; dh[1] = '0;
        win.delete();
        edge_n = 0; last_stb_edge = -1;
    endtask
    // one clock edge: advance the model with the inputs present at the edge, then compare
    task automatic tick();
        bit sp, nd, ns, all_diff;
        logic [W-1:0] sd;
        @(posedge CLK_I);
        edge_n++;
        sp = !bh[1];
        sd = dh[1];
        bh[1] = bh[0]; bh[0] = i_button;
        dh[1] = dh[0]; dh[0] = i_dip;
        ns = rose || (AR && held_ok && m_deb && since == (1 << RB));
        if (ns) begin held_ok = 1; since = 0; end
        else if (!m_deb) held_ok = 0;
        else since++;
        win.push_back(sp);
        if (win.size() > WIN) void'(win.pop_front());
        all_diff = win.size() == WIN;
        foreach (win[i]) if (win[i] == m_deb) all_diff = 0;
        nd = all_diff ? !m_deb : m_deb;
        if (all_diff) win.delete();
        rose = !m_deb && nd;
        m_deb = nd;
        m_stb = ns;
        if (ns) begin m_dat = sd; strobes++; last_stb_edge = edge_n; end
        #1;
        check("stb", bus.STB_O, m_stb);
        check("dat", bus.DAT_O, m_dat);
        check("held", o_held, m_deb);
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic reset_now();
        RST_I = 1'b0;
        model_reset();
        #1;
        check("rst_stb", bus.STB_O, 0);
        check("rst_dat", bus.DAT_O, 0);
        check("rst_held", o_held, 0);
        @(negedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b1;
    endtask
    initial begin
        // 1: clean press with A8 on the switches
        i_dip = 8'hA8;
        reset_now();
        i_button = 1'b0;
        s0 = strobes;
        ticks(40);
        check("t1_count", strobes - s0, AR ? 2 : 1);
        check("t1_first_edge", s0 == 0 ? 11 : 0, 11);
        check("t1_dat", bus.DAT_O, 8'hA8);
        check("t1_held", o_held, 1);
        i_button = 1'b1;
        ticks(20);
        // 2: short glitch is rejected
        s0 = strobes;
        i_button = 1'b0;
        ticks(5);
        i_button = 1'b1;
        ticks(15);
        check("t2_count", strobes - s0, 0);
        check("t2_held", o_held, 0);
        check("t2_dat", bus.DAT_O, 8'hA8);
        // 3: bouncing press, strobe timed from the last bounce
        s0 = strobes;
        i_button = 1'b0; tick();
        i_button = 1'b1; tick();
        i_button = 1'b0; tick();
        i_button = 1'b1; tick();
        i_button = 1'b0;
        mark = edge_n;
        ticks(20);
        check("t3_count", strobes - s0, 1);
        check("t3_edge", last_stb_edge, mark + 11);
        // 4: DIP change while held is ignored until the next press
        i_dip = 8'hCA;
        ticks(3);
        check("t4_dat_held", bus.DAT_O, 8'hA8);
        i_button = 1'b1;
        ticks(15);
        check("t4_dat_idle", bus.DAT_O, 8'hA8);
        i_button = 1'b0;
        ticks(15);
        check("t4_dat_new", bus.DAT_O, 8'hCA);
        // 5: reset on the strobe cycle aborts; reload needs a full debounce
        i_button = 1'b1;
        ticks(15);
        i_button = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = m_stb;
        end
        check("t5_found_stb", found, 1);
        check("t5_dut_stb", bus.STB_O, 1);
        s0 = strobes;
        reset_now();
        ticks(20);
        check("t5_count", strobes - s0, 1);
        check("t5_edge", last_stb_edge, 11);
        // 6: long hold, repeats only with auto-repeat
        i_button = 1'b1;
        ticks(15);
        s0 = strobes;
        i_button = 1'b0;
        mark = edge_n;
        ticks(60);
        check("t6_count", strobes - s0, AR ? 3 : 1);
        check("t6_last", last_stb_edge - mark, AR ? 45 : 11);
        // 7: random button segments and noisy DIP
        for (int seg = 0; seg < 40; seg++) begin
            int len = $urandom_range(1, 14);
            i_button = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                i_dip = W'($urandom);
                tick();
            end
        end
        i_button = 1'b1;
        ticks(20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
